// File: rtl/chess_clock_pkg.sv
// Shared types and BCD time helpers for the chess clock timer.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StExpired = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    digit_t min_tens;
    digit_t min_ones;
    digit_t sec_tens;
    digit_t sec_ones;
  } time_t;

  localparam int unsigned MaxMin = 99;
  localparam int unsigned MaxSec = 59;

  // Build a BCD time from binary minutes (0..99) and seconds (0..59).
  function automatic time_t make_time(input int unsigned mins, input int unsigned secs);
    time_t t;
    t.min_tens = digit_t'(mins / 10);
    t.min_ones = digit_t'(mins % 10);
    t.sec_tens = digit_t'(secs / 10);
    t.sec_ones = digit_t'(secs % 10);
    return t;
  endfunction

  // One-second BCD decrement; caller guarantees t is not 00:00.
  function automatic time_t time_dec(input time_t t);
    time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = 4'd5;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = 4'd9;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Add inc (0..59) seconds with carry into minutes, saturating at 99:59.
  function automatic time_t time_add_sec(input time_t t, input int unsigned inc);
    int unsigned secs;
    int unsigned mins;
    secs = 10 * 32'(t.sec_tens) + 32'(t.sec_ones) + inc;
    mins = 10 * 32'(t.min_tens) + 32'(t.min_ones);
    if (secs > MaxSec) begin
      secs = secs - 60;
      mins = mins + 1;
    end
    if (mins > MaxMin) begin
      mins = MaxMin;
      secs = MaxSec;
    end
    return make_time(mins, secs);
  endfunction

endpackage

// File: rtl/chess_clock_prescaler.sv
// Down-counting prescaler: one tick per CLK_FREQ enabled cycles.
// The count is retained while disabled so a paused clock keeps its sub-second fraction.
module chess_clock_prescaler #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic reload,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_FREQ);
  localparam logic [CntW-1:0] ReloadVal = CntW'(CLK_FREQ - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = enable && (cnt_q == '0);

  // Counter: reload has priority, otherwise count down while enabled and wrap on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ReloadVal;
    end else if (reload) begin
      cnt_q <= ReloadVal;
    end else if (enable) begin
      cnt_q <= (cnt_q == '0) ? ReloadVal : cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/chess_clock_timer.sv
// One player's countdown clock: BCD mm:ss, per-move increment on stop, expiry flag.
module chess_clock_timer
  import chess_clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned INIT_MIN = 5,
  parameter int unsigned INIT_SEC = 0,
  parameter int unsigned INC_SEC  = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_restart,
  input  logic       i_stop,
  output logic       o_zero,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones
);

  localparam time_t InitTime = make_time(INIT_MIN, INIT_SEC);

  state_t state_q;
  time_t  time_q;
  logic   zero_q;
  logic   pre_enable;
  logic   tick;
  time_t  dec_time;

  // Prescaler only advances while actually running; stop and restart freeze/reload it.
  assign pre_enable = (state_q == StRun) && !i_stop && !i_restart;
  assign dec_time   = time_dec(time_q);

  chess_clock_prescaler #(
    .CLK_FREQ (CLK_FREQ)
  ) u_prescaler (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .enable (pre_enable),
    .reload (i_restart),
    .tick   (tick)
  );

  // Control FSM with registered time digits and expiry flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      time_q  <= InitTime;
      zero_q  <= 1'b0;
    end else if (i_restart) begin
      state_q <= StIdle;
      time_q  <= InitTime;
      zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!i_stop) state_q <= StRun;
        end
        StRun: begin
          if (i_stop) begin
            // Stop beats a coinciding tick: credit the increment, skip the decrement.
            state_q <= StIdle;
            time_q  <= time_add_sec(time_q, INC_SEC);
          end else if (tick) begin
            time_q <= dec_time;
            if (dec_time == '0) begin
              state_q <= StExpired;
              zero_q  <= 1'b1;
            end
          end
        end
        StExpired: begin
          time_q <= '0;
          zero_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          time_q  <= InitTime;
          zero_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_zero     = zero_q;
  assign o_min_tens = time_q.min_tens;
  assign o_min_ones = time_q.min_ones;
  assign o_sec_tens = time_q.sec_tens;
  assign o_sec_ones = time_q.sec_ones;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer: four instances with different time settings.
module tb_chess_clock_timer;

  logic clk;
  logic rst_n;
  logic stop_a, stop_b, stop_c, stop_d;
  logic restart_a, restart_b, restart_c, restart_d;
  logic zero_a, zero_b, zero_c, zero_d;
  logic [15:0] time_a, time_b, time_c, time_d;

  int checks;
  int errors;

  // a: 0:03 inc 0, b: 10:00 inc 0, c: 0:03 inc 2, d: 99:59 inc 5
  chess_clock_timer #(.CLK_FREQ(4), .INIT_MIN(0), .INIT_SEC(3), .INC_SEC(0)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_a), .i_stop(stop_a), .o_zero(zero_a),
    .o_min_tens(time_a[15:12]), .o_min_ones(time_a[11:8]),
    .o_sec_tens(time_a[7:4]), .o_sec_ones(time_a[3:0])
  );

  chess_clock_timer #(.CLK_FREQ(4), .INIT_MIN(10), .INIT_SEC(0), .INC_SEC(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_b), .i_stop(stop_b), .o_zero(zero_b),
    .o_min_tens(time_b[15:12]), .o_min_ones(time_b[11:8]),
    .o_sec_tens(time_b[7:4]), .o_sec_ones(time_b[3:0])
  );

  chess_clock_timer #(.CLK_FREQ(4), .INIT_MIN(0), .INIT_SEC(3), .INC_SEC(2)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_c), .i_stop(stop_c), .o_zero(zero_c),
    .o_min_tens(time_c[15:12]), .o_min_ones(time_c[11:8]),
    .o_sec_tens(time_c[7:4]), .o_sec_ones(time_c[3:0])
  );

  chess_clock_timer #(.CLK_FREQ(4), .INIT_MIN(99), .INIT_SEC(59), .INC_SEC(5)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart_d), .i_stop(stop_d), .o_zero(zero_d),
    .o_min_tens(time_d[15:12]), .o_min_ones(time_d[11:8]),
    .o_sec_tens(time_d[7:4]), .o_sec_ones(time_d[3:0])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then sit 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between edges, all players held.
  task automatic do_reset;
    stop_a = 1'b1; stop_b = 1'b1; stop_c = 1'b1; stop_d = 1'b1;
    restart_a = 1'b0; restart_b = 1'b0; restart_c = 1'b0; restart_d = 1'b0;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (time_a !== 16'h0003) begin
      errors++; $display("FAIL reset_a_time: got %h expected %h", time_a, 16'h0003);
    end
    checks++;
    if (zero_a !== 1'b0) begin
      errors++; $display("FAIL reset_a_zero: got %b expected 0", zero_a);
    end
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL reset_b_time: got %h expected %h", time_b, 16'h1000);
    end
    checks++;
    if (time_d !== 16'h9959) begin
      errors++; $display("FAIL reset_d_time: got %h expected %h", time_d, 16'h9959);
    end
    step(100);
    checks++;
    if (time_a !== 16'h0003 || zero_a !== 1'b0) begin
      errors++; $display("FAIL hold_100: got %h/%b expected 0003/0", time_a, zero_a);
    end
  endtask

  task automatic test_run;
    do_reset();
    stop_b = 1'b0;
    step(1);
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL run_start: got %h expected %h", time_b, 16'h1000);
    end
    step(3);
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL run_pre_tick: got %h expected %h", time_b, 16'h1000);
    end
    step(1);
    checks++;
    if (time_b !== 16'h0959) begin
      errors++; $display("FAIL run_tick1: got %h expected %h", time_b, 16'h0959);
    end
    step(3);
    checks++;
    if (time_b !== 16'h0959) begin
      errors++; $display("FAIL run_pre_tick2: got %h expected %h", time_b, 16'h0959);
    end
    step(1);
    checks++;
    if (time_b !== 16'h0958) begin
      errors++; $display("FAIL run_tick2: got %h expected %h", time_b, 16'h0958);
    end
    stop_b = 1'b1;
  endtask

  task automatic test_expire;
    do_reset();
    stop_a = 1'b0;
    step(12);
    checks++;
    if (time_a !== 16'h0001 || zero_a !== 1'b0) begin
      errors++; $display("FAIL pre_expire: got %h/%b expected 0001/0", time_a, zero_a);
    end
    step(1);
    checks++;
    if (time_a !== 16'h0000 || zero_a !== 1'b1) begin
      errors++; $display("FAIL expire: got %h/%b expected 0000/1", time_a, zero_a);
    end
    for (int i = 0; i < 6; i++) begin
      stop_a = i[0];
      step(1);
      checks++;
      if (time_a !== 16'h0000 || zero_a !== 1'b1) begin
        errors++; $display("FAIL expired_hold: got %h/%b expected 0000/1", time_a, zero_a);
      end
    end
    stop_a = 1'b1;
    restart_a = 1'b1;
    step(1);
    restart_a = 1'b0;
    checks++;
    if (time_a !== 16'h0003 || zero_a !== 1'b0) begin
      errors++; $display("FAIL expired_restart: got %h/%b expected 0003/0", time_a, zero_a);
    end
  endtask

  task automatic test_stop_resume;
    do_reset();
    stop_b = 1'b0;
    step(3);
    stop_b = 1'b1;
    step(4);
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL paused: got %h expected %h", time_b, 16'h1000);
    end
    stop_b = 1'b0;
    step(2);
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL resume_pre: got %h expected %h", time_b, 16'h1000);
    end
    step(1);
    checks++;
    if (time_b !== 16'h0959) begin
      errors++; $display("FAIL resume_fraction: got %h expected %h", time_b, 16'h0959);
    end
    stop_b = 1'b1;
  endtask

  task automatic test_increment;
    do_reset();
    stop_c = 1'b0;
    step(5);
    checks++;
    if (time_c !== 16'h0002) begin
      errors++; $display("FAIL inc_pre: got %h expected %h", time_c, 16'h0002);
    end
    stop_c = 1'b1;
    step(1);
    checks++;
    if (time_c !== 16'h0004) begin
      errors++; $display("FAIL inc_add: got %h expected %h", time_c, 16'h0004);
    end
    step(3);
    checks++;
    if (time_c !== 16'h0004) begin
      errors++; $display("FAIL inc_once: got %h expected %h", time_c, 16'h0004);
    end
    stop_d = 1'b0;
    step(2);
    stop_d = 1'b1;
    step(1);
    checks++;
    if (time_d !== 16'h9959) begin
      errors++; $display("FAIL inc_saturate: got %h expected %h", time_d, 16'h9959);
    end
  endtask

  task automatic test_stop_on_tick;
    do_reset();
    stop_c = 1'b0;
    step(4);
    checks++;
    if (time_c !== 16'h0003) begin
      errors++; $display("FAIL sot_pre: got %h expected %h", time_c, 16'h0003);
    end
    stop_c = 1'b1;
    step(1);
    checks++;
    if (time_c !== 16'h0005) begin
      errors++; $display("FAIL stop_on_tick: got %h expected %h", time_c, 16'h0005);
    end
  endtask

  task automatic test_restart;
    do_reset();
    stop_a = 1'b0;
    step(9);
    checks++;
    if (time_a !== 16'h0001) begin
      errors++; $display("FAIL rst_pre: got %h expected %h", time_a, 16'h0001);
    end
    step(1);
    restart_a = 1'b1;
    step(1);
    restart_a = 1'b0;
    checks++;
    if (time_a !== 16'h0003 || zero_a !== 1'b0) begin
      errors++; $display("FAIL restart_mid: got %h/%b expected 0003/0", time_a, zero_a);
    end
    step(4);
    checks++;
    if (time_a !== 16'h0003) begin
      errors++; $display("FAIL restart_idle: got %h expected %h", time_a, 16'h0003);
    end
    step(1);
    checks++;
    if (time_a !== 16'h0002) begin
      errors++; $display("FAIL restart_reload: got %h expected %h", time_a, 16'h0002);
    end
    for (int i = 0; i < 7; i++) begin
      step(1);
      checks++;
      if (zero_a !== 1'b0) begin
        errors++; $display("FAIL restart_zero_run: got %b expected 0", zero_a);
      end
    end
    checks++;
    if (time_a !== 16'h0001) begin
      errors++; $display("FAIL restart_final_pre: got %h expected %h", time_a, 16'h0001);
    end
    restart_a = 1'b1;
    step(1);
    restart_a = 1'b0;
    stop_a = 1'b1;
    checks++;
    if (time_a !== 16'h0003 || zero_a !== 1'b0) begin
      errors++; $display("FAIL restart_final: got %h/%b expected 0003/0", time_a, zero_a);
    end
    step(3);
    checks++;
    if (time_a !== 16'h0003 || zero_a !== 1'b0) begin
      errors++; $display("FAIL restart_after: got %h/%b expected 0003/0", time_a, zero_a);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    stop_b = 1'b0;
    step(5);
    checks++;
    if (time_b !== 16'h0959) begin
      errors++; $display("FAIL areset_pre: got %h expected %h", time_b, 16'h0959);
    end
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (time_b !== 16'h1000 || zero_b !== 1'b0) begin
      errors++; $display("FAIL areset_async: got %h/%b expected 1000/0", time_b, zero_b);
    end
    #2 rst_n = 1'b1;
    step(4);
    checks++;
    if (time_b !== 16'h1000) begin
      errors++; $display("FAIL areset_idle: got %h expected %h", time_b, 16'h1000);
    end
    step(1);
    checks++;
    if (time_b !== 16'h0959) begin
      errors++; $display("FAIL areset_first_tick: got %h expected %h", time_b, 16'h0959);
    end
    stop_b = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    test_reset();
    test_run();
    test_expire();
    test_stop_resume();
    test_increment();
    test_stop_on_tick();
    test_restart();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chess_clock_timer.md
CHESS_CLOCK_TIMER -- requirements
Module: chess_clock_timer

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, clock cycles per second (>=2).
REQ-002 SHALL have parameter INIT_MIN, default 5, initial minutes, 0..99.
REQ-003 SHALL have parameter INIT_SEC, default 0, initial seconds, 0..59; INIT_MIN:INIT_SEC SHALL be nonzero.
REQ-004 SHALL have parameter INC_SEC, default 0, per-move increment in seconds, 0..59.
REQ-005 i_clk  input  1  the only clock; all logic on its rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_restart  input  1  synchronous reload to initial time; driven by the FSM restart output.
REQ-008 i_stop  input  1  level: 0 = this player's clock runs, 1 = held; driven by the FSM per-player stop output.
REQ-009 o_zero  output  1  time expired; drives the FSM per-player zero input.
REQ-010 o_min_tens, o_min_ones, o_sec_tens, o_sec_ones  output  4 each  BCD remaining time, registered.

Function
REQ-011 SHALL implement states IDLE, RUN, EXPIRED.
REQ-012 Priority, highest first: reset, i_restart, expiry, i_stop.
REQ-013 i_restart=1 in any state: next cycle digits = INIT_MIN:INIT_SEC, prescaler = CLK_FREQ-1, state IDLE, o_zero=0; no increment applied.
REQ-014 IDLE with i_stop=0 -> RUN next cycle (1-cycle start latency); IDLE with i_stop=1 -> stay; digits and prescaler hold.
REQ-015 In RUN with i_stop=0, prescaler SHALL count down by 1 per cycle; at 0 it reloads CLK_FREQ-1 and issues a one-cycle tick.
REQ-016 Tick SHALL decrement time by one second in BCD: sec_ones 0->9 borrows, sec_tens 0->5 borrows, min_ones 0->9 borrows, min_tens decrements.
REQ-017 Tick producing 00:00 SHALL set state EXPIRED and o_zero=1 in the same register update as the digits.
REQ-018 EXPIRED SHALL hold digits at 00:00 and o_zero=1, ignore i_stop, exit only via i_restart or reset.
REQ-019 RUN with i_stop=1 -> IDLE next cycle; no decrement that cycle even if prescaler is at 0; prescaler value retained (sub-second fraction kept).
REQ-020 On the RUN->IDLE transition SHALL add INC_SEC seconds in BCD with seconds carry into minutes, saturating at 99:59.
REQ-021 Tick and i_stop=1 in the same cycle: stop wins, increment applied, no decrement.
REQ-022 o_zero SHALL equal (state == EXPIRED); all outputs registered, no combinational path from inputs.
REQ-023 Digits SHALL never hold non-BCD values or seconds > 59.

Reset
REQ-024 i_rst_n=0 SHALL asynchronously force: state IDLE, digits = INIT_MIN:INIT_SEC, prescaler = CLK_FREQ-1, o_zero=0.
REQ-025 Reset deassertion mid-RUN SHALL resume from IDLE, not RUN; first decrement no earlier than CLK_FREQ+1 cycles after i_stop=0 is seen.

Structure
REQ-026 Package chess_clock_pkg SHALL hold the state enum, a 4-bit BCD digit typedef and a packed time struct (min_tens, min_ones, sec_tens, sec_ones).
REQ-027 Sub-module chess_clock_prescaler SHALL hold the prescaler counter (inputs enable, reload; output tick); BCD add/subtract stays in chess_clock_timer.
REQ-028 Two instances (players A and B) SHALL connect to the chess clock FSM without glue logic.

Verification (CLK_FREQ=4 unless stated)
REQ-029 Reset with INIT 0:03 -> outputs 0,0,0,3, o_zero=0; hold i_stop=1 100 cycles -> unchanged.
REQ-030 INIT 10:00, i_stop=0 -> RUN after 1 cycle, 09:59 after 4 further cycles, 09:58 after 8.
REQ-031 INIT 0:03, INC 0, i_stop=0 -> 00:00 with o_zero=1 on the 12th RUN cycle; toggling i_stop afterwards leaves 00:00, o_zero=1.
REQ-032 INIT 0:03, INC 2: run to 00:02 then i_stop=1 -> 00:04 next cycle; INIT 99:59, INC 5, stop before any tick -> 99:59.
REQ-033 i_restart pulse mid-RUN at 00:01 -> next cycle INIT time, IDLE, o_zero=0; restart coinciding with final tick -> INIT time, o_zero never asserted.
REQ-034 i_rst_n pulsed low mid-RUN between clock edges -> outputs reach reset values before the next rising edge.
